word_serializer: RTL and testbench
==================================

# word_serializer

Parallel-in, serial-out stage that feeds the `sequence_detector_101` serial input. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock, LSB first. A one-word holding register lets the next word be accepted while the current one is shifting, so back-to-back words stream with no idle cycles. `serial_out` connects directly to the detector's `serial_in`.

## Interface
- `WIDTH`, 16, word length in bits; legal range ≥ 2.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `in_valid`  in  1  upstream presents a word on `in_data`.
- `in_ready`  out  1  block can accept a word; equals `!hold_full`; combinational.
- `in_data`  in  WIDTH  word to serialize; bit 0 is transmitted first.
- `serial_out`  out  1  current bit, registered; 0 whenever `serial_valid`=0.
- `serial_valid`  out  1  `serial_out` carries a data bit this cycle, registered.
- `word_start`  out  1  high during bit 0 of each word, registered.
- `word_end`  out  1  high during bit WIDTH-1 of each word, registered.
- `busy`  out  1  `serial_valid | hold_full`.

## Operation
- State: FSM {IDLE, SHIFT}; shift register `sh[WIDTH-1:0]`; bit counter `cnt` ($clog2(WIDTH) bits); holding register `hold[WIDTH-1:0]` with flag `hold_full`.
- Accept = `in_valid & in_ready` at a rising edge.
- IDLE and Accept: `in_data` loads into `sh`, `cnt`←0, go to SHIFT. Hold stays empty.
- SHIFT with `cnt`<WIDTH-1: shift `sh` right by one, `cnt`++. Accept loads `hold` and sets `hold_full`.
- SHIFT with `cnt`=WIDTH-1 (last bit on output):
  - `hold_full` set: `hold` loads into `sh`, `cnt`←0, `hold_full`←0, stay in SHIFT.
  - Else if Accept: `in_data` loads directly into `sh`, `cnt`←0, stay in SHIFT.
  - Else: go to IDLE.
- The last-bit reload is gapless: the next word's bit 0 appears on the cycle right after the previous word's bit WIDTH-1.
- `serial_out` = `sh[0]` while in SHIFT.
- `word_start` = SHIFT & `cnt`==0.
- `word_end` = SHIFT & `cnt`==WIDTH-1.
- Backpressure: while `hold_full`=1, `in_ready`=0. The upstream must hold `in_data`/`in_valid` stable until accepted.
- Bits are never dropped, duplicated, or reordered.

## Timing
- Reset values:
  - state IDLE
  - `sh`=0, `cnt`=0, `hold`=0, `hold_full`=0
  - `serial_out`=0, `serial_valid`=0, `word_start`=0, `word_end`=0, `busy`=0
  - `in_ready`=1
- Latency: a word accepted at edge N in IDLE drives bit 0 in cycle N+1 (after edge N) and bit k in cycle N+1+k.
- Throughput: one bit per clock; sustained WIDTH cycles per word with zero gaps when the upstream keeps `in_valid` high.
- Hold reload: `in_ready` returns to 1 in the cycle after the reload edge.
- Reset mid-word or with hold full: both words are discarded. Outputs reach reset values at the reset edge, with no partial-word completion.
- `reset` wins over Accept at the same edge.
- `in_valid` deasserting mid-word has no effect on the word in flight.

## Structure
- Shared package: FSM state encoding (IDLE=0, SHIFT=1) and the default WIDTH constant. The detector bench uses the same WIDTH constant.
- Single module; no sub-module needed.
- `cnt` width is derived via $clog2(WIDTH).

## Test plan
- Reset then single word: accept 16'h4A5B at edge N → bits 1,1,0,1,1,0,1,0,0,1,0,1,0,0,1,0 in cycles N+1..N+16. `word_start` is high at N+1 and `word_end` at N+16. `serial_valid` drops at N+17. Chained into `sequence_detector_101`, the detector output matches the golden sequence for that bit stream.
- Back-to-back: `in_valid` held high with 16'h4A5B then 16'hFFFF → 32 consecutive valid cycles with no gap. The second word is taken into hold at edge N+1. `in_ready` is 0 from N+1 until the reload edge N+16 and 1 again at N+17.
- Three queued words: after 2 words are accepted, the 3rd stalls (`in_ready`=0) with data held stable. It is accepted after the first reload, and all 48 bits are emitted in order.
- Reset mid-word: assert `reset` during bit 5 of 16'hAAAA with hold full → next cycle all outputs are 0, `in_ready`=1, `busy`=0. A fresh word 16'h0001 then emits 1 followed by fifteen 0s.
- Last-bit direct accept: hold empty, `in_valid` rises exactly in the `word_end` cycle with 16'h8000 → accepted that edge. Bit 0 of the new word follows with no gap and hold stays empty.
- Parameter sweep WIDTH=4: word 4'b1011 → 1,1,0,1. `word_start` and `word_end` are 3 cycles apart.

Source files
------------

// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer and the serial stages it feeds.
//   state_t       : serializer FSM encoding (IDLE=0, SHIFT=1)
//   DEFAULT_WIDTH : default word length, also used by the downstream detector bench
package word_serializer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/word_serializer_if.sv
// Handshake and serial-stream bundle for word_serializer.
//   in_valid / in_ready / in_data : upstream word handshake
//   serial_out / serial_valid     : one bit per clock, LSB first
//   word_start / word_end         : framing markers for bit 0 and bit WIDTH-1
//   busy                          : a word is shifting or waiting in the holding register
// Modports: slave = the serializer, master = the word producer / stream consumer.
interface word_serializer_if
    import word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             serial_out;
    logic             serial_valid;
    logic             word_start;
    logic             word_end;
    logic             busy;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output serial_out,
        output serial_valid,
        output word_start,
        output word_end,
        output busy
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  serial_out,
        input  serial_valid,
        input  word_start,
        input  word_end,
        input  busy
    );

endinterface

// File: rtl/word_serializer.sv
// Parallel-in, serial-out stage: accepts WIDTH-bit words on a valid/ready
// handshake and emits them LSB first, one bit per clock. A one-word holding
// register takes the next word while the current one shifts, so consecutive
// words stream without idle cycles.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high; discards any word in flight or held
//   bus   : word_serializer_if.slave (handshake in, serial stream out)
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic            clock,
    input  logic            reset,
    word_serializer_if.slave bus
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_nxt;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] hold_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             hold_full;
    logic             hold_full_nxt;

    logic             serial_out_q;
    logic             serial_valid_q;
    logic             word_start_q;
    logic             word_end_q;
    logic             serial_out_nxt;
    logic             serial_valid_nxt;
    logic             word_start_nxt;
    logic             word_end_nxt;

    logic             accept;

    // Upstream may only be refused while a second word is already parked.
    assign accept = bus.in_valid & ~hold_full;

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            sh             <= '0;
            hold           <= '0;
            cnt            <= '0;
            hold_full      <= 1'b0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            word_start_q   <= 1'b0;
            word_end_q     <= 1'b0;
        end else begin
            state          <= state_nxt;
            sh             <= sh_nxt;
            hold           <= hold_nxt;
            cnt            <= cnt_nxt;
            hold_full      <= hold_full_nxt;
            serial_out_q   <= serial_out_nxt;
            serial_valid_q <= serial_valid_nxt;
            word_start_q   <= word_start_nxt;
            word_end_q     <= word_end_nxt;
        end
    end

    // Next-state logic for the shifter, bit counter and holding register.
    always_comb begin
        state_nxt     = state;
        sh_nxt        = sh;
        hold_nxt      = hold;
        cnt_nxt       = cnt;
        hold_full_nxt = hold_full;

        case (state)
            IDLE: begin
                if (accept) begin
                    sh_nxt    = bus.in_data;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                if (cnt != LAST_BIT) begin
                    sh_nxt  = sh >> 1;
                    cnt_nxt = cnt + CNT_W'(1);
                    if (accept) begin
                        hold_nxt      = bus.in_data;
                        hold_full_nxt = 1'b1;
                    end
                end else if (hold_full) begin
                    // Last bit on the wire: swap in the parked word gaplessly.
                    sh_nxt        = hold;
                    cnt_nxt       = '0;
                    hold_full_nxt = 1'b0;
                end else if (accept) begin
                    // Nothing parked: a word arriving now goes straight to the shifter.
                    sh_nxt  = bus.in_data;
                    cnt_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with sh/cnt.
    always_comb begin
        serial_valid_nxt = (state_nxt == SHIFT);
        serial_out_nxt   = serial_valid_nxt & sh_nxt[0];
        word_start_nxt   = serial_valid_nxt & (cnt_nxt == '0);
        word_end_nxt     = serial_valid_nxt & (cnt_nxt == LAST_BIT);
    end

    assign bus.in_ready     = ~hold_full;
    assign bus.serial_out   = serial_out_q;
    assign bus.serial_valid = serial_valid_q;
    assign bus.word_start   = word_start_q;
    assign bus.word_end     = word_end_q;
    assign bus.busy         = serial_valid_q | hold_full;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer (WIDTH=16 and WIDTH=4 instances) with a
// bit-level scoreboard: each accepted word pushes its bits, each output cycle pops one.
module tb_word_serializer;
    import word_serializer_pkg::*;

    localparam int unsigned W  = DEFAULT_WIDTH;
    localparam int unsigned W4 = 4;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    word_serializer_if #(.WIDTH(W))  bus ();
    word_serializer_if #(.WIDTH(W4)) bus4 ();

    word_serializer #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    word_serializer #(.WIDTH(W4)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    typedef struct {
        logic b;
        int   idx;
    } exp_t;

    exp_t        q[$];
    exp_t        q4[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [15:0] cap;
    int          capn;
    logic [3:0]  cap4;
    int          capn4;
    int          start4 = -1;
    int          end4   = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [15:0] d);
        for (int i = 0; i < int'(W); i++) q.push_back('{b: d[i], idx: i});
    endtask

    task automatic push_word4(input logic [3:0] d);
        for (int i = 0; i < int'(W4); i++) q4.push_back('{b: d[i], idx: i});
    endtask

    task automatic check_main();
        exp_t e;
        logic hf;
        hf = (q.size() > 0) && (q.size() > int'(W) - q[0].idx);
        chk("serial_valid", 32'(bus.serial_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(bus.in_ready), 32'(!hf));
        chk("busy", 32'(bus.busy), 32'((q.size() > 0) || hf));
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("serial_out", 32'(bus.serial_out), 32'(e.b));
            chk("word_start", 32'(bus.word_start), 32'(e.idx == 0));
            chk("word_end", 32'(bus.word_end), 32'(e.idx == int'(W) - 1));
        end else begin
            chk("idle_serial_out", 32'(bus.serial_out), 32'd0);
            chk("idle_word_start", 32'(bus.word_start), 32'd0);
            chk("idle_word_end", 32'(bus.word_end), 32'd0);
        end
        if (bus.serial_valid === 1'b1 && capn < 16) begin
            cap[capn] = bus.serial_out;
            capn++;
        end
    endtask

    task automatic check4();
        exp_t e;
        chk("w4_serial_valid", 32'(bus4.serial_valid), 32'(q4.size() > 0));
        if (q4.size() > 0) begin
            e = q4.pop_front();
            chk("w4_serial_out", 32'(bus4.serial_out), 32'(e.b));
            chk("w4_word_start", 32'(bus4.word_start), 32'(e.idx == 0));
            chk("w4_word_end", 32'(bus4.word_end), 32'(e.idx == int'(W4) - 1));
        end else begin
            chk("w4_idle_serial_out", 32'(bus4.serial_out), 32'd0);
        end
        if (bus4.serial_valid === 1'b1 && capn4 < 4) begin
            cap4[capn4] = bus4.serial_out;
            capn4++;
        end
        if (bus4.word_start === 1'b1 && start4 < 0) start4 = cyc;
        if (bus4.word_end === 1'b1 && end4 < 0) end4 = cyc;
    endtask

    task automatic check_reset();
        chk("rst_serial_out", 32'(bus.serial_out), 32'd0);
        chk("rst_serial_valid", 32'(bus.serial_valid), 32'd0);
        chk("rst_word_start", 32'(bus.word_start), 32'd0);
        chk("rst_word_end", 32'(bus.word_end), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_w4_serial_valid", 32'(bus4.serial_valid), 32'd0);
        chk("rst_w4_in_ready", 32'(bus4.in_ready), 32'd1);
    endtask

    // One clock: note what gets accepted, advance past the edge, then score the outputs.
    task automatic tick(output bit acc);
        bit          acc4;
        logic [15:0] d;
        logic [3:0]  d4;
        acc  = (reset === 1'b0) && (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
        acc4 = (reset === 1'b0) && (bus4.in_valid === 1'b1) && (bus4.in_ready === 1'b1);
        d    = bus.in_data;
        d4   = bus4.in_data;
        @(posedge clock);
        #1;
        cyc++;
        if (reset) begin
            q.delete();
            q4.delete();
            check_reset();
        end else begin
            if (acc) push_word(d);
            if (acc4) push_word4(d4);
            check_main();
            check4();
        end
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < 100 && (q.size() > 0 || q4.size() > 0); i++) tick(a);
        chk("drain_budget", 32'(q.size() + q4.size()), 32'd0);
        tick(a);
    endtask

    initial begin
        bit acc;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus4.in_valid = 1'b0;
        bus4.in_data  = '0;
        capn          = 0;
        capn4         = 0;
        cap           = '0;
        cap4          = '0;

        tick(acc);
        tick(acc);
        reset = 1'b0;
        tick(acc);

        // Single word
        capn         = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h4A5B;
        tick(acc);
        chk("single_accept", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        drain();
        chk("single_word_bits", 32'(cap), 32'h4A5B);

        // Back-to-back, second word parked in hold
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h4A5B;
        tick(acc);
        bus.in_data  = 16'hFFFF;
        tick(acc);
        chk("b2b_hold_accept", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        drain();

        // Three queued words, third stalls until the first reload
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        tick(acc);
        bus.in_data  = 16'h5678;
        tick(acc);
        bus.in_data  = 16'h9ABC;
        tick(acc);
        chk("third_stalls", 32'(acc), 32'd0);
        for (int i = 0; i < 40 && !acc; i++) tick(acc);
        chk("third_accepted", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
        drain();

        // Reset during bit 5 with hold full; reset beats a pending accept
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hAAAA;
        tick(acc);
        bus.in_data  = 16'h5555;
        tick(acc);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick(acc);
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        tick(acc);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        tick(acc);
        capn         = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0001;
        tick(acc);
        bus.in_valid = 1'b0;
        drain();
        chk("post_reset_word", 32'(cap), 32'h0001);

        // Direct accept in the word_end cycle with hold empty
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0F0F;
        tick(acc);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick(acc);
        chk("word_end_cycle", 32'(bus.word_end), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h8000;
        tick(acc);
        chk("direct_accept", 32'(acc), 32'd1);
        chk("direct_start", 32'(bus.word_start), 32'd1);
        bus.in_valid = 1'b0;
        drain();

        // WIDTH=4 instance
        capn4         = 0;
        bus4.in_valid = 1'b1;
        bus4.in_data  = 4'b1011;
        tick(acc);
        bus4.in_valid = 1'b0;
        drain();
        chk("w4_word_bits", 32'(cap4), 32'hB);
        chk("w4_start_end_span", 32'(end4 - start4), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
